i2c_cmd_sequencer: RTL and testbench

//  Upstream command engine for the byte-level i2c master. Accepts a transaction command
//  (7-bit device address, R/W, byte count) plus buffered write bytes. Runs the master's
//  ena_i2c/end_trans handshake byte by byte, returns read bytes and a done/err status.
//  It sits between a register/bus front end and the i2c master. It drives the master's
//  ena_i2c, adrr_r_w, byte_2_send and msb_lsb inputs.

---
 rtl/i2c_seq_pkg.sv | 26 ++
 rtl/i2c_byte_fifo.sv | 63 ++++++
 rtl/i2c_cmd_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_i2c_cmd_sequencer.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_seq_pkg.sv
// Shared types and constants for the i2c command sequencer and its write-byte FIFO.
package i2c_seq_pkg;

    localparam int   LEN_MAX_W = 16;
    localparam logic I2C_RD    = 1'b1;
    localparam logic I2C_WR    = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        STOP
    } state_t;

    typedef struct packed {
        logic [6:0]           addr;
        logic                 rw;
        logic [LEN_MAX_W-1:0] len;
    } i2c_cmd_t;

    // Address byte as the master shifts it out: 7-bit address followed by R/W.
    function automatic logic [7:0] addr_byte(input i2c_cmd_t c);
        return {c.addr, c.rw};
    endfunction

endpackage

// File: rtl/i2c_byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO with occupancy count and a bulk drop
// used to discard the unsent bytes of an aborted write.
module i2c_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             push,
    input  logic [7:0]       push_data,
    input  logic             pop,
    input  logic             drop,
    input  logic [CNT_W-1:0] drop_cnt,
    output logic [7:0]       head,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             empty;
    logic [CNT_W-1:0] pop_amt;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign head    = mem[rd_ptr];

    // A drop never removes more than is stored, so pointers and count stay consistent.
    always_comb begin
        pop_amt = '0;
        if (drop) begin
            pop_amt = (drop_cnt > count) ? count : drop_cnt;
        end else if (pop && !empty) begin
            pop_amt = CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr <= rd_ptr + PTR_W'(pop_amt);
            count  <= count + CNT_W'(push_ok) - pop_amt;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Command engine in front of the byte-level i2c master: sequences the ena_i2c/end_trans
// handshake per byte, feeds write bytes from a FIFO and returns read bytes and status.
module i2c_cmd_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int FIFO_DEPTH   = 16,
    parameter int LEN_W        = 5,
    parameter int TIMEOUT_CYC  = 200_000,
    parameter int STOP_GAP_CYC = 1_000,
    parameter bit MSB_FIRST    = 1'b1
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [6:0]       cmd_addr,
    input  logic             cmd_rw,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [7:0]       wr_data,
    output logic             rd_valid,
    output logic [7:0]       rd_data,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             ena_i2c,
    output logic [7:0]       adrr_r_w,
    output logic [7:0]       byte_2_send,
    output logic             msb_lsb,
    input  logic             end_trans,
    input  logic [7:0]       byte_received
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int GAP_W = $clog2(STOP_GAP_CYC + 1);

    state_t           state;
    state_t           next_state;
    i2c_cmd_t         cmd_q;
    logic [LEN_W-1:0] remaining;
    logic [WD_W-1:0]  wd_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             end_trans_q;
    logic             et_rise;
    logic             running;
    logic             aborted;
    logic             load_next;
    logic             too_long;
    logic             len_fits;
    logic             accept;
    logic             reject;
    logic             timeout;
    logic             gap_done;
    logic             fifo_pop;
    logic             fifo_drop;
    logic [CNT_W-1:0] fifo_count;
    logic [7:0]       fifo_head;
    logic             fifo_full;

    i2c_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .arstn     (arstn),
        .push      (wr_valid),
        .push_data (wr_data),
        .pop       (fifo_pop),
        .drop      (fifo_drop),
        .drop_cnt  (CNT_W'(remaining)),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full)
    );

    assign et_rise  = end_trans & ~end_trans_q;
    assign too_long = (int'(cmd_len) > FIFO_DEPTH);
    assign len_fits = (int'(fifo_count) >= int'(cmd_len));
    assign timeout  = ((state == ADDR) || (state == DATA)) && !et_rise
                      && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
    assign gap_done = (state == STOP) && (gap_cnt == GAP_W'(STOP_GAP_CYC - 1));
    assign wr_ready = ~fifo_full;
    assign msb_lsb  = MSB_FIRST;
    assign adrr_r_w = addr_byte(cmd_q);

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A completed byte takes priority over a watchdog expiry in the same cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept && !reject) begin
                    next_state = ADDR;
                end
            end
            ADDR: begin
                if (et_rise) begin
                    next_state = (cmd_q.len == '0) ? STOP : DATA;
                end else if (timeout) begin
                    next_state = STOP;
                end
            end
            DATA: begin
                if (et_rise && (remaining <= LEN_W'(1))) begin
                    next_state = STOP;
                end else if (timeout) begin
                    next_state = STOP;
                end
            end
            STOP: begin
                if (gap_done) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        cmd_ready = running && (state == IDLE)
                    && ((cmd_rw == I2C_RD) || too_long || len_fits);
        accept    = cmd_valid && cmd_ready;
        reject    = accept && (cmd_rw == I2C_WR) && too_long;
        fifo_pop  = (state == DATA) && et_rise && (cmd_q.rw == I2C_WR)
                    && (remaining != '0);
        fifo_drop = timeout && (cmd_q.rw == I2C_WR);
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            wd_cnt <= '0;
        end else if (accept || et_rise) begin
            wd_cnt <= '0;
        end else if (((state == ADDR) || (state == DATA)) && (wd_cnt != WD_W'(TIMEOUT_CYC))) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            gap_cnt <= '0;
        end else if (state != STOP) begin
            gap_cnt <= '0;
        end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
        end
    end

    // The next write byte is loaded one cycle after a pop, once the FIFO head has moved.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            end_trans_q <= 1'b0;
            running     <= 1'b0;
            ena_i2c     <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            byte_2_send <= '0;
            cmd_q       <= '0;
            remaining   <= '0;
            aborted     <= 1'b0;
            load_next   <= 1'b0;
        end else begin
            end_trans_q <= end_trans;
            running     <= 1'b1;
            ena_i2c     <= (next_state == ADDR) || (next_state == DATA);
            rd_valid    <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            load_next   <= fifo_pop;
            if (accept && !reject) begin
                cmd_q.addr <= cmd_addr;
                cmd_q.rw   <= cmd_rw;
                cmd_q.len  <= LEN_MAX_W'(cmd_len);
                remaining  <= cmd_len;
                aborted    <= 1'b0;
                if ((cmd_rw == I2C_WR) && (cmd_len != '0)) begin
                    byte_2_send <= fifo_head;
                end
            end
            if (reject) begin
                done <= 1'b1;
                err  <= 1'b1;
            end
            if ((state == DATA) && et_rise && (remaining != '0)) begin
                remaining <= remaining - LEN_W'(1);
                if (cmd_q.rw == I2C_RD) begin
                    rd_data  <= byte_received;
                    rd_valid <= 1'b1;
                end
            end
            if (load_next && (state == DATA)) begin
                byte_2_send <= fifo_head;
            end
            if (timeout) begin
                aborted <= 1'b1;
            end
            if (gap_done) begin
                done <= 1'b1;
                err  <= aborted;
            end
        end
    end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Randomized scoreboard bench for i2c_cmd_sequencer with a behavioural i2c master model.
module tb_i2c_cmd_sequencer;

    localparam int FIFO_DEPTH   = 16;
    localparam int LEN_W        = 5;
    localparam int TIMEOUT_CYC  = 400;
    localparam int STOP_GAP_CYC = 30;
    localparam int PERIOD       = 40;

    localparam int K_ADDR = 0;
    localparam int K_WR   = 1;
    localparam int K_RD   = 2;
    localparam int K_DONE = 3;

    typedef struct {
        int         kind;
        logic [7:0] val;
    } ev_t;

    logic             clk;
    logic             arstn;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [6:0]       cmd_addr;
    logic             cmd_rw;
    logic [LEN_W-1:0] cmd_len;
    logic             wr_valid;
    logic             wr_ready;
    logic [7:0]       wr_data;
    logic             rd_valid;
    logic [7:0]       rd_data;
    logic             busy;
    logic             done;
    logic             err;
    logic             ena_i2c;
    logic [7:0]       adrr_r_w;
    logic [7:0]       byte_2_send;
    logic             msb_lsb;
    logic             end_trans;
    logic [7:0]       byte_received;

    ev_t        exp_q[$];
    logic [7:0] ref_fifo[$];
    logic [7:0] rd_src[$];
    logic [7:0] rd_plan[$];
    int         total = 0;
    int         bad   = 0;
    bit         stall = 1'b0;

    i2c_cmd_sequencer #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .LEN_W        (LEN_W),
        .TIMEOUT_CYC  (TIMEOUT_CYC),
        .STOP_GAP_CYC (STOP_GAP_CYC),
        .MSB_FIRST    (1'b1)
    ) dut (
        .clk           (clk),
        .arstn         (arstn),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_addr      (cmd_addr),
        .cmd_rw        (cmd_rw),
        .cmd_len       (cmd_len),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_data       (wr_data),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .ena_i2c       (ena_i2c),
        .adrr_r_w      (adrr_r_w),
        .byte_2_send   (byte_2_send),
        .msb_lsb       (msb_lsb),
        .end_trans     (end_trans),
        .byte_received (byte_received)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900_000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] simulation time limit");
    end

    function automatic string kname(input int k);
        case (k)
            K_ADDR:  return "addr";
            K_WR:    return "wbyte";
            K_RD:    return "rbyte";
            default: return "done_err";
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic compareEv(input int kind, input logic [7:0] val);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL unexpected_%s actual=%0h required=none", kname(kind), val);
        end else begin
            e = exp_q.pop_front();
            if ((e.kind != kind) || (e.val !== val)) begin
                bad++;
                $display("[TB] FAIL event actual=%s:%0h required=%s:%0h",
                         kname(kind), val, kname(e.kind), e.val);
            end
        end
    endtask

    task automatic expectEv(input int kind, input logic [7:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    // Master model: one-cycle end_trans pulse every PERIOD clocks while ena_i2c is high.
    initial begin
        int tick;
        int idx;
        tick          = 0;
        idx           = 0;
        end_trans     = 1'b0;
        byte_received = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            end_trans = 1'b0;
            if (!arstn || !ena_i2c) begin
                tick = 0;
                idx  = 0;
            end else begin
                tick++;
                if ((tick >= PERIOD) && !(stall && (idx >= 1))) begin
                    tick = 0;
                    if ((idx > 0) && adrr_r_w[0]) begin
                        if (rd_src.size() > 0) byte_received = rd_src.pop_front();
                        else byte_received = 8'h00;
                    end
                    end_trans = 1'b1;
                    idx++;
                end
            end
        end
    end

    // Monitor: turns observed DUT activity into events and checks them against the queue.
    initial begin
        int mon_idx;
        int since_et;
        mon_idx  = 0;
        since_et = 1000;
        forever begin
            @(negedge clk);
            if (!arstn) begin
                mon_idx = 0;
            end else begin
                if (end_trans) begin
                    if (mon_idx == 0) compareEv(K_ADDR, adrr_r_w);
                    else if (!adrr_r_w[0]) compareEv(K_WR, byte_2_send);
                    mon_idx++;
                    since_et = 0;
                end else begin
                    since_et++;
                    if (!ena_i2c) mon_idx = 0;
                end
                if (rd_valid) compareEv(K_RD, rd_data);
                if (done) begin
                    compareEv(K_DONE, {7'b0, err});
                    if (!err) begin
                        total++;
                        if ((since_et < STOP_GAP_CYC) || (since_et > STOP_GAP_CYC + 2)) begin
                            bad++;
                            $display("[TB] FAIL stop_gap actual=%0d required=%0d..%0d",
                                     since_et, STOP_GAP_CYC, STOP_GAP_CYC + 2);
                        end
                    end
                end else if (err) begin
                    checkOutput("err_without_done", 8'(err), 8'h00);
                end
            end
        end
    end

    task automatic pushByte(input logic [7:0] b);
        @(posedge clk);
        #1;
        wr_valid = 1'b1;
        wr_data  = b;
        @(negedge clk);
        checkOutput("wr_ready", 8'(wr_ready), 8'(ref_fifo.size() < FIFO_DEPTH));
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        if (ref_fifo.size() < FIFO_DEPTH) ref_fifo.push_back(b);
    endtask

    task automatic probeReady(input logic rw, input int len);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_rw    = rw;
        cmd_len   = LEN_W'(len);
        @(negedge clk);
        checkOutput("cmd_ready", 8'(cmd_ready),
                    8'(rw || (len > FIFO_DEPTH) || (ref_fifo.size() >= len)));
    endtask

    // Reference behaviour of one accepted command, expressed as the event list it must produce.
    task automatic predictCmd(input logic [6:0] a, input logic rw, input int len);
        logic [7:0] b;
        if (!rw && (len > FIFO_DEPTH)) begin
            expectEv(K_DONE, 8'h01);
        end else begin
            expectEv(K_ADDR, {a, rw});
            if (stall && (len > 0)) begin
                if (!rw) begin
                    repeat (len) if (ref_fifo.size() > 0) b = ref_fifo.pop_front();
                end
                expectEv(K_DONE, 8'h01);
            end else begin
                for (int i = 0; i < len; i++) begin
                    if (rw) begin
                        if (rd_plan.size() > 0) b = rd_plan.pop_front();
                        else b = 8'($urandom_range(0, 255));
                        rd_src.push_back(b);
                        expectEv(K_RD, b);
                    end else begin
                        expectEv(K_WR, ref_fifo.pop_front());
                    end
                end
                expectEv(K_DONE, 8'h00);
            end
        end
    endtask

    task automatic applyStimulus(input logic [6:0] a, input logic rw, input int len);
        bit ok;
        @(posedge clk);
        #1;
        cmd_addr  = a;
        cmd_rw    = rw;
        cmd_len   = LEN_W'(len);
        cmd_valid = 1'b1;
        ok        = 1'b0;
        for (int i = 0; (i < 3000) && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) ok = 1'b1;
            @(posedge clk);
        end
        #1;
        cmd_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("[TB] FAIL cmd_accept actual=not_ready required=accepted");
        end else begin
            predictCmd(a, rw, len);
        end
    endtask

    task automatic waitDone(input int budget);
        for (int i = 0; (i < budget) && (exp_q.size() != 0); i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain actual=%0d_pending required=0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
    endtask

    function automatic int budgetFor(input int len);
        return (len + 2) * PERIOD + TIMEOUT_CYC + STOP_GAP_CYC + 100;
    endfunction

    initial begin
        logic [6:0] a;
        logic       rw;
        int         len;
        int         extra;

        arstn     = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_rw    = 1'b0;
        cmd_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ena_i2c", 8'(ena_i2c), 8'h00);
        checkOutput("rst_busy", 8'(busy), 8'h00);
        checkOutput("rst_done", 8'(done), 8'h00);
        checkOutput("rst_err", 8'(err), 8'h00);
        checkOutput("rst_rd_valid", 8'(rd_valid), 8'h00);
        checkOutput("rst_rd_data", rd_data, 8'h00);
        checkOutput("rst_adrr_r_w", adrr_r_w, 8'h00);
        checkOutput("rst_byte_2_send", byte_2_send, 8'h00);
        checkOutput("rst_cmd_ready", 8'(cmd_ready), 8'h00);
        checkOutput("rst_wr_ready", 8'(wr_ready), 8'h01);
        checkOutput("rst_msb_lsb", 8'(msb_lsb), 8'h01);
        @(posedge clk);
        #1;
        arstn = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] single byte write");
        pushByte(8'h55);
        applyStimulus(7'h50, 1'b0, 1);
        waitDone(budgetFor(1));
        checkOutput("ena_after_done", 8'(ena_i2c), 8'h00);
        checkOutput("busy_after_done", 8'(busy), 8'h00);

        $display("[TB] three byte read");
        rd_plan.push_back(8'h11);
        rd_plan.push_back(8'h22);
        rd_plan.push_back(8'h33);
        applyStimulus(7'h50, 1'b1, 3);
        waitDone(budgetFor(3));

        $display("[TB] write waits for FIFO fill");
        pushByte(8'hA1);
        pushByte(8'hB2);
        probeReady(1'b0, 4);
        pushByte(8'hC3);
        probeReady(1'b0, 4);
        pushByte(8'hD4);
        probeReady(1'b0, 4);
        applyStimulus(7'h2C, 1'b0, 4);
        waitDone(budgetFor(4));

        $display("[TB] full FIFO and 16 byte write");
        for (int i = 0; i < FIFO_DEPTH + 1; i++) pushByte(8'($urandom_range(0, 255)));
        applyStimulus(7'h3B, 1'b0, 16);
        waitDone(budgetFor(16));

        $display("[TB] oversize write rejected");
        applyStimulus(7'h11, 1'b0, 20);
        waitDone(budgetFor(0));

        $display("[TB] watchdog abort");
        repeat (3) pushByte(8'($urandom_range(0, 255)));
        stall = 1'b1;
        applyStimulus(7'h44, 1'b0, 3);
        waitDone(budgetFor(3));
        stall = 1'b0;
        checkOutput("ena_after_abort", 8'(ena_i2c), 8'h00);
        probeReady(1'b0, 1);

        $display("[TB] randomized commands");
        for (int n = 0; n < 20; n++) begin
            a  = 7'($urandom_range(0, 127));
            rw = 1'($urandom_range(0, 1));
            if (rw) begin
                len = $urandom_range(0, 6);
            end else begin
                len   = $urandom_range(0, 18);
                extra = $urandom_range(0, 2);
                if (len <= FIFO_DEPTH) begin
                    while (ref_fifo.size() < len) pushByte(8'($urandom_range(0, 255)));
                end
                repeat (extra) pushByte(8'($urandom_range(0, 255)));
            end
            probeReady(rw, len);
            stall = ($urandom_range(0, 7) == 0);
            applyStimulus(a, rw, len);
            waitDone(budgetFor(len));
            stall = 1'b0;
        end

        $display("[TB] reset during data phase");
        while (ref_fifo.size() < 4) pushByte(8'($urandom_range(0, 255)));
        applyStimulus(7'h5A, 1'b0, 4);
        repeat (2 * PERIOD + 20) @(posedge clk);
        #1;
        arstn = 1'b0;
        exp_q.delete();
        ref_fifo.delete();
        rd_src.delete();
        @(negedge clk);
        checkOutput("midrst_ena_i2c", 8'(ena_i2c), 8'h00);
        checkOutput("midrst_busy", 8'(busy), 8'h00);
        checkOutput("midrst_done", 8'(done), 8'h00);
        repeat (3) @(posedge clk);
        #1;
        arstn = 1'b1;
        repeat (3 * STOP_GAP_CYC) @(posedge clk);
        applyStimulus(7'h27, 1'b0, 0);
        waitDone(budgetFor(0));

        checkOutput("leftover_events", 8'(exp_q.size()), 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
